// File: rtl/debug_frame_tx.sv
// Latches a snapshot on request and sends it to the UART TX FIFO as a frame:
// header, 16-bit byte count, data bytes MSB first, then an optional XOR checksum.
module debug_frame_tx #(
  parameter int          DATA_W      = 1712,
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter bit          CHECKSUM_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              send_signal,
  input  logic [DATA_W-1:0] send_data,
  input  logic              tx_full,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              busy,
  output logic              data_sent
);

  localparam int NBYTES = (DATA_W + 7) / 8;
  localparam int SNAP_W = NBYTES * 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [15:0]      LEN      = 16'(NBYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, HDR, LEN_HI, LEN_LO, DATA, CSUM, DONE} state_t;

  state_t            r_state;
  logic [SNAP_W-1:0] r_snap;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_csum;
  logic [7:0]        w_byte;
  state_t            w_next;

  // Byte for the current state and the state to move to on its gap edge.
  always_comb begin
    w_byte = 8'h00;
    w_next = IDLE;
    case (r_state)
      HDR: begin
        w_byte = HEADER;
        w_next = LEN_HI;
      end
      LEN_HI: begin
        w_byte = LEN[15:8];
        w_next = LEN_LO;
      end
      LEN_LO: begin
        w_byte = LEN[7:0];
        w_next = DATA;
      end
      DATA: begin
        w_byte = r_snap[SNAP_W-1 -: 8];
        w_next = (r_idx == '0) ? (CHECKSUM_EN ? CSUM : DONE) : DATA;
      end
      CSUM: begin
        w_byte = r_csum;
        w_next = DONE;
      end
      default: begin
        w_byte = 8'h00;
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_snap    <= '0;
      r_idx     <= '0;
      r_csum    <= 8'h00;
      wr_uart   <= 1'b0;
      w_data    <= 8'h00;
      busy      <= 1'b0;
      data_sent <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          data_sent <= 1'b0;
          if (send_signal) begin
            r_snap  <= SNAP_W'(send_data);
            r_csum  <= 8'h00;
            r_idx   <= IDX_LAST;
            busy    <= 1'b1;
            r_state <= HDR;
          end
        end
        DONE: begin
          data_sent <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          // A strobe is always followed by a gap cycle so tx_full can catch up.
          if (wr_uart) begin
            wr_uart <= 1'b0;
            r_state <= w_next;
            if (r_state == DATA && r_idx != '0) begin
              r_idx  <= r_idx - 1'b1;
              r_snap <= r_snap << 8;
            end
            if (w_next == DONE) begin
              data_sent <= 1'b1;
              busy      <= 1'b0;
            end
          end else if (!tx_full) begin
            wr_uart <= 1'b1;
            w_data  <= w_byte;
            if (r_state == LEN_HI || r_state == LEN_LO || r_state == DATA)
              r_csum <= r_csum ^ w_byte;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench: three instances (16-bit, 12-bit, 8-bit without checksum)
// with a negedge monitor capturing each strobed byte and its cycle number.
module tb_debug_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  send = '0;
  logic [2:0]  full = '0;
  logic [15:0] sd16 = '0;
  logic [11:0] sd12 = '0;
  logic [7:0]  sd8  = '0;
  wire  [2:0]  wr, busy, dsent;
  wire  [7:0]  wd [3];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] q [3][$];
  int         t [3][$];
  int         ds_cnt [3];
  int         ds_cyc [3];
  logic       ds_busy [3];
  int         nbusy_lo [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debug_frame_tx #(.DATA_W(16), .HEADER(8'hA5), .CHECKSUM_EN(1'b1)) u_d16 (
    .clk(clk), .reset(rst), .send_signal(send[0]), .send_data(sd16), .tx_full(full[0]),
    .wr_uart(wr[0]), .w_data(wd[0]), .busy(busy[0]), .data_sent(dsent[0]));

  debug_frame_tx #(.DATA_W(12), .HEADER(8'hA5), .CHECKSUM_EN(1'b1)) u_d12 (
    .clk(clk), .reset(rst), .send_signal(send[1]), .send_data(sd12), .tx_full(full[1]),
    .wr_uart(wr[1]), .w_data(wd[1]), .busy(busy[1]), .data_sent(dsent[1]));

  debug_frame_tx #(.DATA_W(8), .HEADER(8'hA5), .CHECKSUM_EN(1'b0)) u_d8 (
    .clk(clk), .reset(rst), .send_signal(send[2]), .send_data(sd8), .tx_full(full[2]),
    .wr_uart(wr[2]), .w_data(wd[2]), .busy(busy[2]), .data_sent(dsent[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wr[i]) begin
        q[i].push_back(wd[i]);
        t[i].push_back(cyc);
        if (!busy[i]) nbusy_lo[i]++;
      end
      if (dsent[i]) begin
        ds_cnt[i]++;
        ds_cyc[i]  = cyc;
        ds_busy[i] = busy[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      t[i].delete();
      ds_cnt[i]   = 0;
      nbusy_lo[i] = 0;
    end
  endtask

  // Pulse send on the selected instances; returns the cycle number of the accept edge.
  task automatic start(input logic [2:0] m, output int a);
    @(negedge clk);
    send = m;
    @(posedge clk);
    #1 a = cyc;
    @(negedge clk);
    send = '0;
  endtask

  task automatic wait_ds(input int i);
    int n = 0;
    while (ds_cnt[i] == 0 && n < 200) begin
      @(negedge clk);
      #1 n++;
    end
    check($sformatf("ds_timeout_dut%0d", i), 32'(ds_cnt[i] != 0), 32'd1);
  endtask

  task automatic check_frame(input int i, input int a, input logic [7:0] e [8],
                             input int n, input bit chk_t);
    check($sformatf("nbytes_dut%0d", i), 32'(q[i].size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      if (k < q[i].size()) begin
        check($sformatf("byte%0d_dut%0d", k, i), 32'(q[i][k]), 32'(e[k]));
        if (chk_t) check($sformatf("time%0d_dut%0d", k, i), 32'(t[i][k]), 32'(a + 1 + 2*k));
      end
    end
    check($sformatf("ds_count_dut%0d", i), 32'(ds_cnt[i]), 32'd1);
    if (chk_t) check($sformatf("ds_time_dut%0d", i), 32'(ds_cyc[i]), 32'(a + 2*n));
    check($sformatf("ds_busy_dut%0d", i), 32'(ds_busy[i]), 32'd0);
    check($sformatf("busy_drop_dut%0d", i), 32'(nbusy_lo[i]), 32'd0);
  endtask

  initial begin
    logic [7:0] e16 [8];
    logic [7:0] e12 [8];
    logic [7:0] e8  [8];
    int a, f, n;
    e16 = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h24, 8'h00, 8'h00};
    e12 = '{8'hA5, 8'h00, 8'h02, 8'h0A, 8'hBC, 8'hB4, 8'h00, 8'h00};
    e8  = '{8'hA5, 8'h00, 8'h01, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    clr();

    #12;
    check("rst_wr",    32'(wr[0]),    32'd0);
    check("rst_wdata", 32'(wd[0]),    32'h00);
    check("rst_busy",  32'(busy[0]),  32'd0);
    check("rst_dsent", 32'(dsent[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frames on all three instances in parallel
    sd16 = 16'h1234; sd12 = 12'hABC; sd8 = 8'h5A;
    start(3'b111, a);
    wait_ds(0);
    wait_ds(1);
    wait_ds(2);
    repeat (3) @(negedge clk);
    check_frame(0, a, e16, 6, 1'b1);
    check_frame(1, a, e12, 6, 1'b1);
    check_frame(2, a, e8, 4, 1'b1);
    check("idle_busy", 32'(busy[0]), 32'd0);

    // Backpressure right after the header strobe
    clr();
    start(3'b001, a);
    n = 0;
    while (q[0].size() < 1 && n < 50) begin
      @(negedge clk);
      #1 n++;
    end
    full[0] = 1'b1;
    repeat (10) @(negedge clk);
    check("stall_no_wr", 32'(q[0].size()), 32'd1);
    full[0] = 1'b0;
    f = cyc;
    wait_ds(0);
    repeat (2) @(negedge clk);
    check_frame(0, a, e16, 6, 1'b0);
    if (q[0].size() > 1) check("stall_resume", 32'(t[0][1]), 32'(f + 1));

    // Request isolation: changed data, mid-frame request, request during data_sent
    clr();
    sd16 = 16'h1234;
    start(3'b001, a);
    sd16 = 16'hFFFF;
    n = 0;
    while (q[0].size() < 2 && n < 50) begin
      @(negedge clk);
      #1 n++;
    end
    send[0] = 1'b1;
    @(negedge clk);
    #1 send[0] = 1'b0;
    n = 0;
    while (!dsent[0] && n < 100) begin
      @(negedge clk);
      #1 n++;
    end
    send[0] = 1'b1;
    @(negedge clk);
    #1 send[0] = 1'b0;
    repeat (30) @(negedge clk);
    check_frame(0, a, e16, 6, 1'b1);
    check("iso_idle", 32'(busy[0]), 32'd0);

    // Asynchronous reset in the DATA state
    clr();
    sd16 = 16'h1234;
    start(3'b001, a);
    n = 0;
    while (q[0].size() < 4 && n < 50) begin
      @(negedge clk);
      #1 n++;
    end
    check("pre_rst_wr", 32'(wr[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("async_wr",    32'(wr[0]),    32'd0);
    check("async_busy",  32'(busy[0]),  32'd0);
    check("async_dsent", 32'(dsent[0]), 32'd0);
    check("async_wdata", 32'(wd[0]),    32'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_ds", 32'(ds_cnt[0]), 32'd0);
    clr();
    start(3'b001, a);
    wait_ds(0);
    repeat (2) @(negedge clk);
    check_frame(0, a, e16, 6, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
